// File: rtl/spi_in_rx.sv
// Slave-side 3-wire SPI word receiver, oversampled on the local clock.
// Optional build macro SPI_RX_TIMEOUT_EN adds a 1024-cycle frame inactivity timeout.
module spi_in_rx #(
  parameter int unsigned SPI_LEN     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sclk,
  input  logic               din,
  input  logic               sync_n,
  output logic [SPI_LEN-1:0] data_out,
  output logic               valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int unsigned CW = $clog2(SPI_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_FULL,
    S_ERR
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;
  logic [SYNC_STAGES-1:0] r_syn_sync;
  logic                   r_sclk_d;
  logic                   r_din_d;
  logic                   r_syn_d;
  logic                   r_sclk_fall;
  logic                   r_syn_fall;
  logic                   r_syn_rise;
  logic                   w_sclk_s;
  logic                   w_din_s;
  logic                   w_syn_s;
  logic                   w_sclk_fall;
  logic                   w_syn_fall;
  logic                   w_syn_rise;

  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [SPI_LEN-1:0]     r_shift;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_din_s     = r_din_sync[SYNC_STAGES-1];
  assign w_syn_s     = r_syn_sync[SYNC_STAGES-1];
  assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
  assign w_syn_fall  = r_syn_d & ~w_syn_s;
  assign w_syn_rise  = ~r_syn_d & w_syn_s;

  // Synchronizers preset to idle-high; edge pulses and din are registered once more so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync <= '1;
      r_din_sync  <= '1;
      r_syn_sync  <= '1;
      r_sclk_d    <= 1'b1;
      r_din_d     <= 1'b1;
      r_syn_d     <= 1'b1;
      r_sclk_fall <= 1'b0;
      r_syn_fall  <= 1'b0;
      r_syn_rise  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din};
      r_syn_sync  <= {r_syn_sync[SYNC_STAGES-2:0], sync_n};
      r_sclk_d    <= w_sclk_s;
      r_din_d     <= w_din_s;
      r_syn_d     <= w_syn_s;
      r_sclk_fall <= w_sclk_fall;
      r_syn_fall  <= w_syn_fall;
      r_syn_rise  <= w_syn_rise;
    end
  end

`ifdef SPI_RX_TIMEOUT_EN
  localparam int unsigned TO_W = 10;
  logic            r_any_edge;
  logic [TO_W-1:0] r_idle_cnt;
  logic            w_timeout;

  assign w_timeout = (r_idle_cnt == {TO_W{1'b1}});

  // Inactivity counter restarts on any sclk or sync_n transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any_edge <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_any_edge <= (r_sclk_d ^ w_sclk_s) | (r_syn_d ^ w_syn_s);
      if (r_state == S_IDLE || r_any_edge || w_timeout) begin
        r_idle_cnt <= '0;
      end else begin
        r_idle_cnt <= r_idle_cnt + TO_W'(1);
      end
    end
  end
`else
  logic w_timeout;
  assign w_timeout = 1'b0;
`endif

  // Frame FSM; a sync_n rise always takes priority over a coincident sclk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_syn_fall) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_state <= S_RECV;
            busy    <= 1'b1;
          end
        end
        S_RECV: begin
          if (r_syn_rise || w_timeout) begin
            frame_err <= 1'b1;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end else if (r_sclk_fall) begin
            r_shift <= {r_shift[SPI_LEN-2:0], r_din_d};
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == CW'(SPI_LEN - 1)) begin
              r_state <= S_FULL;
            end
          end
        end
        S_FULL: begin
          if (r_syn_rise) begin
            data_out <= r_shift;
            valid    <= 1'b1;
            r_state  <= S_IDLE;
            busy     <= 1'b0;
          end else if (w_timeout) begin
            frame_err <= 1'b1;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end else if (r_sclk_fall) begin
            r_state <= S_ERR;
          end
        end
        S_ERR: begin
          if (r_syn_rise || w_timeout) begin
            frame_err <= 1'b1;
            r_state   <= S_IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_in_rx.sv
// Randomized self-checking bench for spi_in_rx against a frame-level reference model.
module tb_spi_in_rx;
  localparam int unsigned SPI_LEN     = 8;
  localparam int unsigned SYNC_STAGES = 2;

  logic               clk    = 1'b0;
  logic               rst    = 1'b1;
  logic               sclk   = 1'b1;
  logic               din    = 1'b1;
  logic               sync_n = 1'b1;
  logic [SPI_LEN-1:0] data_out;
  logic               valid;
  logic               frame_err;
  logic               busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int          n_valid = 0;
  int          n_err   = 0;
  int          cyc     = 0;
  int          valid_cyc = 0;
  int          rise_cyc  = 0;
  logic        prev_busy = 1'b0;
  logic [SPI_LEN-1:0] got_q[$];
  logic [SPI_LEN-1:0] model_data = '0;

  spi_in_rx #(.SPI_LEN(SPI_LEN), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .din(din), .sync_n(sync_n),
    .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts pulses and checks busy drops together with valid.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        n_valid++;
        valid_cyc = cyc;
        got_q.push_back(data_out);
        chk("busy_with_valid", 32'(busy), 32'd0);
        chk("busy_before_valid", 32'(prev_busy), 32'd1);
      end
      if (frame_err) n_err++;
    end
    prev_busy = busy;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit b[$], input int half, input int gap);
    sync_n = 1'b0;
    wait_clk(half);
    foreach (b[i]) begin
      din = b[i];
      wait_clk(half);
      sclk = 1'b0;
      wait_clk(half);
      if (i == 0) chk("busy_mid", 32'(busy), 32'd1);
      sclk = 1'b1;
    end
    wait_clk(half);
    sync_n = 1'b1;
    rise_cyc = cyc;
    wait_clk(gap);
  endtask

  function automatic bit [SPI_LEN-1:0] pack_word(input bit b[$]);
    int unsigned w = 0;
    for (int i = 0; i < b.size() && i < int'(SPI_LEN); i++) w = w * 2 + int'(b[i]);
    return SPI_LEN'(w);
  endfunction

  function automatic void to_bits(input int unsigned w, input int n, output bit b[$]);
    b = {};
    for (int i = n - 1; i >= 0; i--) b.push_back(bit'((w >> i) & 1));
  endfunction

  // Run one frame and compare against the model: exactly SPI_LEN falls is good, anything else an error.
  task automatic frame_check(input string tag, input bit b[$], input int half);
    int nv0, ne0;
    bit ok;
    nv0 = n_valid;
    ne0 = n_err;
    ok  = (b.size() == int'(SPI_LEN));
    send_frame(b, half, 10);
    if (ok) model_data = pack_word(b);
    chk({tag, "_valid"}, 32'(n_valid - nv0), ok ? 32'd1 : 32'd0);
    chk({tag, "_err"}, 32'(n_err - ne0), ok ? 32'd0 : 32'd1);
    chk({tag, "_data"}, 32'(data_out), 32'(model_data));
  endtask

  initial begin
    bit b[$];
    bit b2[$];
    int nv0, ne0;

    wait_clk(3);
    rst = 1'b0;
    wait_clk(20);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    to_bits(32'hA5, 8, b);
    frame_check("a5", b, 4);
    chk("a5_latency", 32'(valid_cyc - rise_cyc), 32'(SYNC_STAGES + 2));

    nv0 = n_valid;
    got_q = {};
    to_bits(32'h3C, 8, b);
    to_bits(32'hFF, 8, b2);
    send_frame(b, 4, 4);
    send_frame(b2, 4, 10);
    model_data = 8'hFF;
    chk("b2b_count", 32'(n_valid - nv0), 32'd2);
    if (got_q.size() == 2) begin
      chk("b2b_first", 32'(got_q[0]), 32'h3C);
      chk("b2b_second", 32'(got_q[1]), 32'hFF);
    end else begin
      chk("b2b_queue", 32'(got_q.size()), 32'd2);
    end

    to_bits(32'h15, 5, b);
    frame_check("short5", b, 4);
    to_bits(32'h1AB, 9, b);
    frame_check("over9", b, 5);

    // Reset mid-frame after four bits of 0x81.
    ne0 = n_err;
    nv0 = n_valid;
    to_bits(32'h8, 4, b);
    sync_n = 1'b0;
    wait_clk(4);
    foreach (b[i]) begin
      din = b[i];
      wait_clk(4);
      sclk = 1'b0;
      wait_clk(4);
      sclk = 1'b1;
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_err", 32'(frame_err), 32'd0);
    model_data = '0;
    sync_n = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(5);
    chk("mid_rst_no_pulse", 32'((n_err - ne0) + (n_valid - nv0)), 32'd0);
    to_bits(32'h81, 8, b);
    frame_check("post_rst81", b, 4);

    for (int k = 0; k < 30; k++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : int'(SPI_LEN);
      to_bits($urandom, n, b);
      frame_check("rand", b, int'($urandom_range(3, 6)));
    end

`ifdef SPI_RX_TIMEOUT_EN
    ne0 = n_err;
    nv0 = n_valid;
    to_bits(32'h5, 3, b);
    sync_n = 1'b0;
    wait_clk(4);
    foreach (b[i]) begin
      din = b[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(1100);
    chk("to_err", 32'(n_err - ne0), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    sclk = 1'b1;
    sync_n = 1'b1;
    wait_clk(10);
    chk("to_late_rise_err", 32'(n_err - ne0), 32'd1);
    chk("to_late_rise_valid", 32'(n_valid - nv0), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
